// File: rtl/core_pkg.sv
// Shared core types: instruction bundle from ReadMem, write-back control, load-size encodings.
// Also holds the write-back FSM state type and the captured-load record.
package core;

    localparam int ADDR_WIDTH     = 32;
    localparam int DATA_WIDTH     = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int INSN_WIDTH     = 32;

    localparam logic [1:0] LS_BYTE = 2'd0;
    localparam logic [1:0] LS_HALF = 2'd1;
    localparam logic [1:0] LS_WORD = 2'd2;

    typedef struct packed {
        logic                  valid;
        logic [ADDR_WIDTH-1:0] addr;
        logic [INSN_WIDTH-1:0] insn;
    } InsnBundle;

    typedef struct packed {
        logic                      wb_en;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic                      is_load;
        logic [1:0]                load_size;
        logic                      load_unsigned;
        logic [1:0]                byte_off;
    } WbCtrl;

    typedef enum logic {
        WB_IDLE,
        WB_WAIT_LOAD
    } wb_state_e;

    // Everything a load needs to remember while its response is outstanding.
    typedef struct packed {
        logic [ADDR_WIDTH-1:0]     addr;
        logic                      wb_en;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic [1:0]                load_size;
        logic                      load_unsigned;
        logic [1:0]                byte_off;
    } PendLoad;

    // x0 is hardwired to zero, so a write to it is dropped.
    function automatic logic rd_writes(input logic wb_en, input logic [REG_ADDR_WIDTH-1:0] rd);
        return wb_en && (rd != '0);
    endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load extraction: selects byte/half by byte offset, then sign- or zero-extends.
// Only instantiated by write_back_stage when WB_LOAD_EXT_EN is defined.
module load_align
    import core::*;
(
    input  logic [DATA_WIDTH-1:0] word_i,
    input  logic [1:0]            load_size_i,
    input  logic                  load_unsigned_i,
    input  logic [1:0]            byte_off_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    logic [DATA_WIDTH-1:0] shifted;
    logic                  byte_sign;
    logic                  half_sign;

    // Misaligned halves simply take the low 16 bits after the shift (upper bits fall off).
    assign shifted   = word_i >> {byte_off_i, 3'b000};
    assign byte_sign = ~load_unsigned_i & shifted[7];
    assign half_sign = ~load_unsigned_i & shifted[15];

    always_comb begin
        data_o = word_i;
        case (load_size_i)
            LS_BYTE: data_o = {{(DATA_WIDTH-8){byte_sign}}, shifted[7:0]};
            LS_HALF: data_o = {{(DATA_WIDTH-16){half_sign}}, shifted[15:0]};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/write_back_stage.sv
// Final pipeline stage: writes ALU/load results to the register file, retires, counts instret.
// Optional feature macro: WB_LOAD_EXT_EN (load byte/half extraction and extension via load_align).
module write_back_stage
    import core::*;
#(
    parameter int ADDR_WIDTH     = core::ADDR_WIDTH,
    parameter int DATA_WIDTH     = core::DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = core::REG_ADDR_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  InsnBundle                 insn,
    input  WbCtrl                     wb,
    input  logic [DATA_WIDTH-1:0]     alu_data,
    output logic                      in_ready,
    input  logic                      mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]     mem_rsp_data,
    output logic                      mem_rsp_ready,
    output logic                      rf_we,
    output logic [REG_ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0]     rf_wdata,
    output logic                      retire_valid,
    output logic [ADDR_WIDTH-1:0]     retire_addr,
    output logic [63:0]               instret
);

    wb_state_e                 state_q, state_d;
    PendLoad                   pend_q, pend_d;
    logic                      rf_we_q, rf_we_d;
    logic [REG_ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_WIDTH-1:0]     rf_wdata_q, rf_wdata_d;
    logic                      retire_valid_q, retire_valid_d;
    logic [ADDR_WIDTH-1:0]     retire_addr_q, retire_addr_d;
    logic [63:0]               instret_q, instret_d;
    logic [DATA_WIDTH-1:0]     load_data;
    logic                      unused_insn_bits;

    assign unused_insn_bits = ^insn.insn;

`ifdef WB_LOAD_EXT_EN
    load_align u_load_align (
        .word_i          (mem_rsp_data),
        .load_size_i     (pend_q.load_size),
        .load_unsigned_i (pend_q.load_unsigned),
        .byte_off_i      (pend_q.byte_off),
        .data_o          (load_data)
    );
`else
    logic unused_ext_fields;

    assign load_data         = mem_rsp_data;
    assign unused_ext_fields = ^{pend_q.load_size, pend_q.load_unsigned, pend_q.byte_off};
`endif

    assign in_ready      = (state_q == WB_IDLE);
    assign mem_rsp_ready = (state_q == WB_WAIT_LOAD);

    always_comb begin
        state_d        = state_q;
        pend_d         = pend_q;
        rf_we_d        = 1'b0;
        rf_waddr_d     = rf_waddr_q;
        rf_wdata_d     = rf_wdata_q;
        retire_valid_d = 1'b0;
        retire_addr_d  = retire_addr_q;

        case (state_q)
            WB_IDLE: begin
                if (insn.valid) begin
                    if (wb.is_load) begin
                        pend_d.addr          = insn.addr;
                        pend_d.wb_en         = wb.wb_en;
                        pend_d.rd            = wb.rd;
                        pend_d.load_size     = wb.load_size;
                        pend_d.load_unsigned = wb.load_unsigned;
                        pend_d.byte_off      = wb.byte_off;
                        state_d              = WB_WAIT_LOAD;
                    end else begin
                        rf_we_d        = rd_writes(wb.wb_en, wb.rd);
                        rf_waddr_d     = wb.rd;
                        rf_wdata_d     = alu_data;
                        retire_valid_d = 1'b1;
                        retire_addr_d  = insn.addr;
                    end
                end
            end
            WB_WAIT_LOAD: begin
                if (mem_rsp_valid) begin
                    rf_we_d        = rd_writes(pend_q.wb_en, pend_q.rd);
                    rf_waddr_d     = pend_q.rd;
                    rf_wdata_d     = load_data;
                    retire_valid_d = 1'b1;
                    retire_addr_d  = pend_q.addr;
                    state_d        = WB_IDLE;
                end
            end
            default: state_d = WB_IDLE;
        endcase

        // Counter moves in the same cycle the retire pulse becomes visible.
        instret_d = instret_q + {63'd0, retire_valid_d};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= WB_IDLE;
            pend_q         <= '0;
            rf_we_q        <= 1'b0;
            rf_waddr_q     <= '0;
            rf_wdata_q     <= '0;
            retire_valid_q <= 1'b0;
            retire_addr_q  <= '0;
            instret_q      <= '0;
        end else begin
            state_q        <= state_d;
            pend_q         <= pend_d;
            rf_we_q        <= rf_we_d;
            rf_waddr_q     <= rf_waddr_d;
            rf_wdata_q     <= rf_wdata_d;
            retire_valid_q <= retire_valid_d;
            retire_addr_q  <= retire_addr_d;
            instret_q      <= instret_d;
        end
    end

    assign rf_we        = rf_we_q;
    assign rf_waddr     = rf_waddr_q;
    assign rf_wdata     = rf_wdata_q;
    assign retire_valid = retire_valid_q;
    assign retire_addr  = retire_addr_q;
    assign instret      = instret_q;

endmodule

// File: tb/tb_write_back_stage.sv
// Self-checking bench for write_back_stage: directed steps then randomized traffic
// against a transaction-level model of accept / load-wait / retire behaviour.
module tb_write_back_stage;
    import core::*;

    logic            clk;
    logic            rst;
    InsnBundle       insn_s;
    WbCtrl           wb_s;
    logic [31:0]     alu_data;
    logic            in_ready;
    logic            mem_rsp_valid;
    logic [31:0]     mem_rsp_data;
    logic            mem_rsp_ready;
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [31:0]     rf_wdata;
    logic            retire_valid;
    logic [31:0]     retire_addr;
    logic [63:0]     instret;

    write_back_stage dut (
        .clk           (clk),
        .rst           (rst),
        .insn          (insn_s),
        .wb            (wb_s),
        .alu_data      (alu_data),
        .in_ready      (in_ready),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .mem_rsp_ready (mem_rsp_ready),
        .rf_we         (rf_we),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .retire_valid  (retire_valid),
        .retire_addr   (retire_addr),
        .instret       (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic        m_busy = 1'b0;
    logic [63:0] m_instret = 64'd0;
    logic [31:0] p_addr;
    logic        p_en;
    logic [4:0]  p_rd;
    logic [1:0]  p_size;
    logic        p_uns;
    logic [1:0]  p_off;
    logic        acc;
    logic        last_ret;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] load_value(input logic [31:0] raw, input logic [1:0] size,
                                               input logic uns, input logic [1:0] off);
`ifdef WB_LOAD_EXT_EN
        logic [31:0] sh;
        sh = raw / (32'd1 << (8 * off));
        if (size == 2'd0) return uns ? {24'd0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
        if (size == 2'd1) return uns ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
        return raw;
`else
        logic unused_args;
        unused_args = ^{size, uns, off};
        return raw;
`endif
    endfunction

    // Apply current inputs for one clock edge, then compare outputs against the model.
    task automatic tick();
        logic        e_ret, e_we;
        logic [4:0]  e_wa;
        logic [31:0] e_wd, e_ra;
        e_ret = 1'b0; e_we = 1'b0; e_wa = '0; e_wd = '0; e_ra = '0;
        acc = 1'b0;
        if (rst) begin
            m_busy = 1'b0;
            m_instret = 64'd0;
        end else if (!m_busy && insn_s.valid) begin
            acc = 1'b1;
            if (wb_s.is_load) begin
                m_busy = 1'b1;
                p_addr = insn_s.addr; p_en = wb_s.wb_en; p_rd = wb_s.rd;
                p_size = wb_s.load_size; p_uns = wb_s.load_unsigned; p_off = wb_s.byte_off;
            end else begin
                e_ret = 1'b1;
                e_we  = wb_s.wb_en && (wb_s.rd != 5'd0);
                e_wa  = wb_s.rd;
                e_wd  = alu_data;
                e_ra  = insn_s.addr;
            end
        end else if (m_busy && mem_rsp_valid) begin
            e_ret  = 1'b1;
            e_we   = p_en && (p_rd != 5'd0);
            e_wa   = p_rd;
            e_wd   = load_value(mem_rsp_data, p_size, p_uns, p_off);
            e_ra   = p_addr;
            m_busy = 1'b0;
        end
        if (e_ret) m_instret = m_instret + 64'd1;
        @(posedge clk);
        @(negedge clk);
        last_ret = retire_valid;
        chk("in_ready", {63'd0, in_ready}, {63'd0, !m_busy});
        chk("mem_rsp_ready", {63'd0, mem_rsp_ready}, {63'd0, m_busy});
        chk("retire_valid", {63'd0, retire_valid}, {63'd0, e_ret});
        chk("rf_we", {63'd0, rf_we}, {63'd0, e_we});
        if (e_we) begin
            chk("rf_waddr", {59'd0, rf_waddr}, {59'd0, e_wa});
            chk("rf_wdata", {32'd0, rf_wdata}, {32'd0, e_wd});
        end
        if (e_ret) chk("retire_addr", {32'd0, retire_addr}, {32'd0, e_ra});
        chk("instret", instret, m_instret);
        $display("t=%0t rst=%0b v=%0b ld=%0b rsp=%0b | in_rdy=%0b rsp_rdy=%0b we=%0b rd=%0d wd=%08h ret=%0b ra=%08h instret=%0d",
                 $time, rst, insn_s.valid, wb_s.is_load, mem_rsp_valid, in_ready, mem_rsp_ready,
                 rf_we, rf_waddr, rf_wdata, retire_valid, retire_addr, instret);
    endtask

    task automatic set_nl(input logic [31:0] addr, input logic [4:0] rd, input logic en, input logic [31:0] alu);
        insn_s = '{valid: 1'b1, addr: addr, insn: $urandom()};
        wb_s   = '{wb_en: en, rd: rd, is_load: 1'b0, load_size: 2'($urandom_range(0, 2)),
                   load_unsigned: 1'($urandom_range(0, 1)), byte_off: 2'($urandom_range(0, 3))};
        alu_data = alu;
    endtask

    task automatic set_ld(input logic [31:0] addr, input logic [4:0] rd, input logic en,
                          input logic [1:0] size, input logic uns, input logic [1:0] off);
        insn_s   = '{valid: 1'b1, addr: addr, insn: $urandom()};
        wb_s     = '{wb_en: en, rd: rd, is_load: 1'b1, load_size: size, load_unsigned: uns, byte_off: off};
        alu_data = $urandom();
    endtask

    task automatic set_idle();
        insn_s.valid  = 1'b0;
        mem_rsp_valid = 1'b0;
    endtask

    // Load issued now; `delay` waiting cycles with no response, then the response.
    task automatic run_load(input logic [31:0] addr, input logic [4:0] rd, input logic en,
                            input logic [1:0] size, input logic uns, input logic [1:0] off,
                            input logic [31:0] data, input int delay, output int low_cycles);
        low_cycles = 0;
        set_ld(addr, rd, en, size, uns, off);
        tick();
        if (!in_ready) low_cycles++;
        set_idle();
        for (int i = 0; i < delay; i++) begin
            tick();
            if (!in_ready) low_cycles++;
        end
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = data;
        tick();
        if (!in_ready) low_cycles++;
        mem_rsp_valid = 1'b0;
    endtask

    initial begin
        int low;
        int pulses;
        logic [31:0] exp_ext;

        rst = 1'b1;
        insn_s = '0;
        wb_s = '0;
        alu_data = '0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data = '0;
        @(negedge clk);

        // Reset state
        tick();
        tick();
        chk("reset_rf_waddr", {59'd0, rf_waddr}, 64'd0);
        chk("reset_rf_wdata", {32'd0, rf_wdata}, 64'd0);
        chk("reset_retire_addr", {32'd0, retire_addr}, 64'd0);
        rst = 1'b0;
        tick();

        // Single non-load
        set_nl(32'h100, 5'd5, 1'b1, 32'hDEADBEEF);
        tick();
        chk("nl_wdata", {32'd0, rf_wdata}, 64'hDEADBEEF);
        chk("nl_instret", instret, 64'd1);
        set_idle();
        tick();

        // Load with response held off for 4 cycles
        run_load(32'h200, 5'd3, 1'b1, LS_WORD, 1'b0, 2'd0, 32'h12345678, 4, low);
        chk("ld_low_cycles", 64'(low), 64'd5);
        chk("ld_wdata", {32'd0, rf_wdata}, 64'h12345678);
        chk("ld_waddr", {59'd0, rf_waddr}, 64'd3);
        chk("ld_instret", instret, 64'd2);
        tick();

        // rd = 0 non-load and load: retire without write
        set_nl(32'h300, 5'd0, 1'b1, 32'h55555555);
        tick();
        set_idle();
        run_load(32'h304, 5'd0, 1'b1, LS_WORD, 1'b0, 2'd0, 32'h66666666, 0, low);
        chk("rd0_instret", instret, 64'd4);
        // wb_en = 0 with nonzero rd also suppresses the write
        set_nl(32'h308, 5'd7, 1'b0, 32'h77777777);
        tick();
        set_idle();

        // Byte load, offset 2, signed then unsigned
`ifdef WB_LOAD_EXT_EN
        exp_ext = 32'hFFFFFF80;
`else
        exp_ext = 32'h0080FF00;
`endif
        run_load(32'h400, 5'd9, 1'b1, LS_BYTE, 1'b0, 2'd2, 32'h0080FF00, 1, low);
        chk("ext_signed", {32'd0, rf_wdata}, {32'd0, exp_ext});
`ifdef WB_LOAD_EXT_EN
        exp_ext = 32'h00000080;
`endif
        run_load(32'h404, 5'd9, 1'b1, LS_BYTE, 1'b1, 2'd2, 32'h0080FF00, 0, low);
        chk("ext_unsigned", {32'd0, rf_wdata}, {32'd0, exp_ext});

        // Reset while a load is pending; the late response must be ignored
        set_ld(32'h500, 5'd4, 1'b1, LS_WORD, 1'b0, 2'd0);
        tick();
        set_idle();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h0000AAAA;
        tick();
        chk("rstwait_rf_we", {63'd0, rf_we}, 64'd0);
        chk("rstwait_instret", instret, 64'd0);
        chk("rstwait_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rstwait_rsp_ready", {63'd0, mem_rsp_ready}, 64'd0);
        mem_rsp_valid = 1'b0;

        // Preload counter near wrap, then 10 back-to-back non-loads
        force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFE;
        #1;
        release dut.instret_q;
        m_instret = 64'hFFFF_FFFF_FFFF_FFFE;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            set_nl(32'h600 + 32'(i), 5'($urandom_range(1, 31)), 1'b1, $urandom());
            tick();
            if (last_ret) pulses++;
        end
        set_idle();
        chk("b2b_pulses", 64'(pulses), 64'd10);
        chk("wrap_instret", instret, 64'd8);

        // Randomized traffic; upstream holds an instruction until it is accepted
        insn_s.valid = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!insn_s.valid || acc) begin
                if ($urandom_range(0, 9) < 7) begin
                    if ($urandom_range(0, 9) < 3)
                        set_ld($urandom(), 5'($urandom()), 1'($urandom()), 2'($urandom_range(0, 2)),
                               1'($urandom()), 2'($urandom()));
                    else
                        set_nl($urandom(), 5'($urandom()), 1'($urandom_range(0, 3) != 0), $urandom());
                end else begin
                    insn_s.valid = 1'b0;
                end
            end
            mem_rsp_valid = ($urandom_range(0, 9) < 4);
            mem_rsp_data  = $urandom();
            tick();
        end
        set_idle();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
